// File: rtl/bcd_pkg.sv
// Shared BCD types, limits and helpers for the BCD datapath blocks.
package bcd_pkg;
    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic bcd_digit_valid(bcd_digit_t d);
        return d <= BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/data bundle between a BCD counter and its user.
interface bcd_updown_counter_if #(parameter int unsigned DIGITS = 3);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  en;
    logic                  up;
    logic [4*DIGITS-1:0]   count;
    logic                  tc;
    logic                  load_err;

    modport master (output load, load_val, en, up, input count, tc, load_err);
    modport slave  (input load, load_val, en, up, output count, tc, load_err);
endinterface

// File: rtl/bcd_digit_step.sv
// One BCD digit of the up/down ripple chain; cin requests a step of this digit.
module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    input  logic       cin,
    input  logic       up,
    output bcd_digit_t d_next,
    output logic       cout
);
    always_comb begin
        d_next = d;
        cout   = 1'b0;
        if (cin) begin
            if (up) begin
                if (d == BCD_MAX) begin
                    d_next = BCD_MIN;
                    cout   = 1'b1;
                end else begin
                    d_next = d + 4'd1;
                end
            end else begin
                if (d == BCD_MIN) begin
                    d_next = BCD_MAX;
                    cout   = 1'b1;
                end else begin
                    d_next = d - 4'd1;
                end
            end
        end
    end
endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit packed-BCD up/down counter with validated load, wrap/saturate limits
// and one-cycle terminal-count / load-error pulses.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter bit          WRAP   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    bcd_updown_counter_if.slave bus
);
    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0]      count_q, count_d;
    logic              tc_q, tc_d;
    logic              load_err_q, load_err_d;
    logic [W-1:0]      stepped;
    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] dig_ok;
    logic              load_ok;
    logic              limit;

    // Load has priority, so a step is only injected when no load is present.
    assign carry[0] = bus.en & ~bus.load;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_step u_step (
            .d      (count_q[4*g +: 4]),
            .cin    (carry[g]),
            .up     (bus.up),
            .d_next (stepped[4*g +: 4]),
            .cout   (carry[g+1])
        );
        assign dig_ok[g] = bcd_digit_valid(bus.load_val[4*g +: 4]);
    end

    assign load_ok = &dig_ok;
    // Carry/borrow out of the top digit means the count sat at a limit.
    assign limit   = carry[DIGITS];

    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (load_ok) count_d    = bus.load_val;
            else         load_err_d = 1'b1;
        end else begin
            tc_d = limit;
            if (!limit || WRAP) count_d = stepped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.tc       = tc_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: vector table, corner sequences and a
// randomized run against an integer-arithmetic reference model.
module tb_bcd_updown_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    bcd_updown_counter_if #(.DIGITS(3)) ifa ();
    bcd_updown_counter_if #(.DIGITS(3)) ifb ();
    bcd_updown_counter_if #(.DIGITS(4)) ifc ();

    bcd_updown_counter #(.DIGITS(3), .WRAP(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    bcd_updown_counter #(.DIGITS(3), .WRAP(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct {
        bit          rst;
        bit          load;
        logic [11:0] lv;
        bit          en;
        bit          up;
        logic [11:0] exp_cnt;
        bit          exp_tc;
        bit          exp_le;
    } vec_t;

    vec_t vecs[18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int bcd2int(input logic [31:0] v, input int d);
        int r = 0;
        for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input int n, input int d);
        logic [31:0] v = '0;
        for (int i = 0; i < d; i++) begin
            v[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return v;
    endfunction

    function automatic bit bcd_ok(input logic [31:0] v, input int d);
        for (int i = 0; i < d; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Counter as a plain integer modulo 10^d, with limits decided numerically.
    task automatic model(input int d, input bit wrap, input logic [31:0] cur,
                         input bit r, input bit ld, input logic [31:0] lv,
                         input bit e, input bit u,
                         output logic [31:0] nxt, output bit tc, output bit le);
        int lim = 1;
        int n;
        for (int i = 0; i < d; i++) lim = lim * 10;
        nxt = cur; tc = 1'b0; le = 1'b0;
        if (r) begin
            nxt = '0;
        end else if (ld) begin
            if (bcd_ok(lv, d)) nxt = lv;
            else le = 1'b1;
        end else if (e) begin
            n = bcd2int(cur, d);
            if (u) begin
                if (n == lim - 1) begin tc = 1'b1; nxt = wrap ? int2bcd(0, d) : cur; end
                else nxt = int2bcd(n + 1, d);
            end else begin
                if (n == 0) begin tc = 1'b1; nxt = wrap ? int2bcd(lim - 1, d) : cur; end
                else nxt = int2bcd(n - 1, d);
            end
        end
    endtask

    task automatic set_b(input bit ld, input logic [11:0] lv, input bit e, input bit u);
        ifb.load = ld; ifb.load_val = lv; ifb.en = e; ifb.up = u;
    endtask

    task automatic set_c(input bit ld, input logic [15:0] lv, input bit e, input bit u);
        ifc.load = ld; ifc.load_val = lv; ifc.en = e; ifc.up = u;
    endtask

    initial begin
        logic [31:0] ma, mb, na, nb, lv32;
        bit ta, tb, la, lb, r, ld, e, u, bias;
        int sel;

        ifa.load = 0; ifa.load_val = '0; ifa.en = 0; ifa.up = 0;
        set_b(0, '0, 0, 0);
        set_c(0, '0, 0, 0);

        //          rst ld  lv       en up  cnt      tc le
        vecs[0]  = '{1, 1, 12'h123, 1, 1, 12'h000, 0, 0};
        vecs[1]  = '{1, 1, 12'h123, 1, 1, 12'h000, 0, 0};
        vecs[2]  = '{0, 0, 12'h000, 1, 1, 12'h001, 0, 0};
        vecs[3]  = '{0, 1, 12'h199, 0, 0, 12'h199, 0, 0};
        vecs[4]  = '{0, 0, 12'h000, 1, 1, 12'h200, 0, 0};
        vecs[5]  = '{0, 0, 12'h000, 1, 1, 12'h201, 0, 0};
        vecs[6]  = '{0, 1, 12'h999, 0, 0, 12'h999, 0, 0};
        vecs[7]  = '{0, 0, 12'h000, 1, 1, 12'h000, 1, 0};
        vecs[8]  = '{0, 0, 12'h000, 1, 1, 12'h001, 0, 0};
        vecs[9]  = '{0, 1, 12'h456, 0, 0, 12'h456, 0, 0};
        vecs[10] = '{0, 1, 12'h1A3, 0, 0, 12'h456, 0, 1};
        vecs[11] = '{0, 1, 12'h300, 0, 0, 12'h300, 0, 0};
        vecs[12] = '{0, 0, 12'h000, 0, 0, 12'h300, 0, 0};
        vecs[13] = '{0, 0, 12'h000, 1, 0, 12'h299, 0, 0};
        vecs[14] = '{0, 1, 12'h000, 1, 0, 12'h000, 0, 0};
        vecs[15] = '{0, 0, 12'h000, 1, 0, 12'h999, 1, 0};
        vecs[16] = '{0, 1, 12'hF00, 1, 1, 12'h999, 0, 1};
        vecs[17] = '{1, 0, 12'h000, 1, 1, 12'h000, 0, 0};

        for (int i = 0; i < 18; i++) begin
            rst = vecs[i].rst;
            ifa.load = vecs[i].load; ifa.load_val = vecs[i].lv;
            ifa.en = vecs[i].en; ifa.up = vecs[i].up;
            tick();
            chk($sformatf("vec%0d count", i), 32'(ifa.count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d tc", i), 32'(ifa.tc), 32'(vecs[i].exp_tc));
            chk($sformatf("vec%0d load_err", i), 32'(ifa.load_err), 32'(vecs[i].exp_le));
        end
        rst = 0;
        ifa.load = 0; ifa.en = 0;

        // Saturating counter holds at the limits but still flags tc.
        set_b(1, 12'h000, 0, 0); tick(); chk("sat load0", 32'(ifb.count), 32'h000);
        set_b(0, 12'h000, 1, 0); tick(); chk("sat dn1 count", 32'(ifb.count), 32'h000);
        chk("sat dn1 tc", 32'(ifb.tc), 32'd1);
        tick(); chk("sat dn2 count", 32'(ifb.count), 32'h000);
        chk("sat dn2 tc", 32'(ifb.tc), 32'd1);
        set_b(0, 12'h000, 1, 1); tick(); chk("sat up count", 32'(ifb.count), 32'h001);
        chk("sat up tc", 32'(ifb.tc), 32'd0);
        set_b(1, 12'h999, 0, 0); tick();
        set_b(0, 12'h000, 1, 1); tick(); chk("sat top count", 32'(ifb.count), 32'h999);
        chk("sat top tc", 32'(ifb.tc), 32'd1);
        set_b(0, 12'h000, 0, 0); tick(); chk("sat idle tc", 32'(ifb.tc), 32'd0);

        // Four-digit borrow chain and load beating a same-cycle step.
        set_c(1, 16'h1000, 0, 0); tick(); chk("d4 load", 32'(ifc.count), 32'h1000);
        set_c(0, 16'h0000, 1, 0); tick(); chk("d4 dn count", 32'(ifc.count), 32'h0999);
        chk("d4 dn tc", 32'(ifc.tc), 32'd0);
        set_c(1, 16'h0500, 1, 1); tick(); chk("d4 load+en", 32'(ifc.count), 32'h0500);
        chk("d4 load+en tc", 32'(ifc.tc), 32'd0);
        set_c(0, 16'h0000, 0, 0); tick(); chk("d4 hold", 32'(ifc.count), 32'h0500);

        // Randomized run on both 3-digit counters from a known reset state.
        rst = 1; tick(); rst = 0;
        ma = '0; mb = '0; bias = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 19) == 0) bias = ~bias;
            sel = $urandom_range(0, 99);
            r  = (sel < 2);
            ld = (sel >= 2 && sel < 12);
            case ($urandom_range(0, 3))
                0: lv32 = 32'($urandom_range(0, 4095));
                1: lv32 = 32'h999;
                2: lv32 = 32'h000;
                default: lv32 = int2bcd($urandom_range(0, 999), 3);
            endcase
            e = ($urandom_range(0, 3) != 0);
            u = ($urandom_range(0, 4) == 0) ? ~bias : bias;
            rst = r;
            ifa.load = ld; ifa.load_val = lv32[11:0]; ifa.en = e; ifa.up = u;
            set_b(ld, lv32[11:0], e, u);
            model(3, 1'b1, ma, r, ld, lv32, e, u, na, ta, la);
            model(3, 1'b0, mb, r, ld, lv32, e, u, nb, tb, lb);
            tick();
            ma = na; mb = nb;
            chk($sformatf("rnd%0d wrap count", c), 32'(ifa.count), ma);
            chk($sformatf("rnd%0d wrap flags", c), {30'd0, ifa.tc, ifa.load_err}, {30'd0, ta, la});
            chk($sformatf("rnd%0d sat count", c), 32'(ifb.count), mb);
            chk($sformatf("rnd%0d sat flags", c), {30'd0, ifb.tc, ifb.load_err}, {30'd0, tb, lb});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised N-digit packed-BCD up/down counter: the next-generation replacement for the fixed 3-digit BCD incrementor.
- Adds reset, synchronous load with digit validation, enable, direction control, selectable wrap/saturate mode, and a terminal-count flag.
- Feeds BCD display/readout paths and event-tally logic. All outputs are registered.

Parameters:
- DIGITS, 3, number of BCD digits (1..8); data width is 4*DIGITS.
- WRAP, 1, 1 = roll over at the limits (all-9 up to 0, 0 down to all-9); 0 = saturate at the limits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  load load_val into the count this cycle.
- load_val  input  4*DIGITS  packed BCD value to load; digit 0 is in bits [3:0].
- en  input  1  count enable, one step per cycle.
- up  input  1  1 = increment, 0 = decrement; sampled only when en=1.
- count  output  4*DIGITS  current packed BCD count.
- tc  output  1  terminal-count pulse, one cycle wide.
- load_err  output  1  load rejected pulse, one cycle wide.

Behaviour:
- Single clock domain; reset is synchronous and active-high on rst. Every output updates only on the rising edge of clk.
- Reset: count=0, tc=0, load_err=0. rst overrides every other input, including a step in progress.
- Per-cycle priority: rst > load > en. With no action, count holds and tc=load_err=0 on the next cycle.
- Load:
  - If every digit of load_val is ≤9, count<=load_val next cycle.
  - If any digit is >9, count holds and load_err=1 for one cycle.
  - tc is always 0 on a load cycle. en is ignored when load=1.
- Increment (en=1, up=1): per-digit ripple with carry.
  - Digit 9 becomes 0 and carries into the next digit; digit <9 adds 1 and the carry stops.
  - Carry out of the top digit (count was all-9):
    - WRAP=1: count becomes 0, tc=1.
    - WRAP=0: count holds at all-9, tc=1.
- Decrement (en=1, up=0): per-digit ripple with borrow.
  - Digit 0 becomes 9 and borrows from the next digit; digit >0 subtracts 1.
  - Borrow out of the top digit (count was 0):
    - WRAP=1: count becomes all-9, tc=1.
    - WRAP=0: count holds at 0, tc=1.
- Latency: one cycle from the enabled edge to the updated count. tc and load_err are asserted in the same cycle as the count update they describe.
- Count is guaranteed valid BCD at all times, because non-BCD loads are rejected and reset clears to 0.
- Back-to-back en=1 steps once per cycle; a direction change between cycles takes effect immediately.
- Carry/borrow chain is combinational across all DIGITS and closes within one cycle. The result is never truncated into a non-BCD digit.
- Control FSM is implicit: IDLE (no en/load) / STEP / LOAD / LIMIT (limit reached). No extra state is kept beyond count and the two flag registers.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - Constants BCD_MAX=4'd9 and BCD_MIN=4'd0.
  - Function bcd_digit_valid(d), which returns d ≤ 9.
  - Shared with future BCD blocks (adders, binary-to-BCD converters).
- Sub-module bcd_digit_step (combinational):
  - Inputs: d, cin (carry or borrow in), up.
  - Outputs: d_next, cout.
  - Instantiated DIGITS times in a generate chain.
  - cin of digit 0 is tied to en & ~load.
- Top level holds the registers, the load-validation reduction, the limit/WRAP logic and the flag generation.

Test Plan (DIGITS=3 unless noted):
- Reset with load=1 and en=1 both held → count=12'h000, tc=0, load_err=0. Release → counting starts on the next edge.
- Load 12'h199, then en=1, up=1 for 2 cycles → count 12'h200 then 12'h201, tc=0 throughout.
- WRAP=1: load 12'h999, one up step → count=12'h000, tc=1 for exactly one cycle. Next step → 12'h001, tc=0.
- WRAP=0: load 12'h000, two down steps → count holds 12'h000, tc=1 on both cycles. Then one up step → 12'h001.
- Load 12'h1A3 (invalid middle digit) while count=12'h456 → count stays 12'h456, load_err=1 for one cycle. Then load 12'h300 → count=12'h300, load_err=0.
- DIGITS=4, WRAP=1: load 16'h1000, one down step → 16'h0999. Then load=1 and en=1 in the same cycle with load_val=16'h0500 → count=16'h0500, with no step applied.
